// File: rtl/register_file_write_arbiter_if.sv
// Write-port bundle between two writeback requesters, the arbiter and the register file.
// The master side drives requests; the slave side is the arbiter.
interface register_file_write_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     request_valid_0;
  logic                     request_ready_0;
  logic [ADDRESS_WIDTH-1:0] request_address_0;
  logic [DATA_WIDTH-1:0]    request_data_0;
  logic                     request_valid_1;
  logic                     request_ready_1;
  logic [ADDRESS_WIDTH-1:0] request_address_1;
  logic [DATA_WIDTH-1:0]    request_data_1;
  logic                     write_enabled;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     grant_index;
  logic                     init_done;

  modport master (
    output request_valid_0, request_address_0, request_data_0,
    output request_valid_1, request_address_1, request_data_1,
    input  request_ready_0, request_ready_1,
    input  write_enabled, write_address, write_data, grant_index, init_done
  );

  modport slave (
    input  request_valid_0, request_address_0, request_data_0,
    input  request_valid_1, request_address_1, request_data_1,
    output request_ready_0, request_ready_1,
    output write_enabled, write_address, write_data, grant_index, init_done
  );
endinterface

// File: rtl/register_file_write_arbiter.sv
// Register file write-port sequencer: zeroes every register after reset, then
// round-robins the single write port between two valid/ready writeback requesters.
module register_file_write_arbiter #(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                           clock,
  input logic                           reset_n,
  register_file_write_arbiter_if.slave  bus
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clear_counter_q, clear_counter_d;
  logic                     last_grant_q, last_grant_d;
  logic                     write_enabled_q, write_enabled_d;
  logic [ADDRESS_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic                     grant_index_q, grant_index_d;
  logic                     init_done_q, init_done_d;

  logic grant_0, grant_1;
  logic ready_0, ready_1;
  logic transfer_0, transfer_1;

  // With both valid, the requester that did not win last time gets the port.
  always_comb begin
    grant_0    = bus.request_valid_0 && (!bus.request_valid_1 || last_grant_q);
    grant_1    = bus.request_valid_1 && (!bus.request_valid_0 || !last_grant_q);
    ready_0    = (state_q == RUN) && grant_0;
    ready_1    = (state_q == RUN) && grant_1;
    transfer_0 = bus.request_valid_0 && ready_0;
    transfer_1 = bus.request_valid_1 && ready_1;
  end

  always_comb begin
    state_d         = state_q;
    clear_counter_d = clear_counter_q;
    last_grant_d    = last_grant_q;
    write_enabled_d = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    grant_index_d   = grant_index_q;
    init_done_d     = init_done_q;

    case (state_q)
      CLEAR: begin
        write_enabled_d = 1'b1;
        write_address_d = clear_counter_q;
        write_data_d    = '0;
        clear_counter_d = clear_counter_q + 1'b1;
        if (&clear_counter_q) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // Register 0 is hardwired zero: accept the request but suppress the write.
        if (transfer_0) begin
          grant_index_d = 1'b0;
          last_grant_d  = 1'b0;
          if (bus.request_address_0 != '0) begin
            write_enabled_d = 1'b1;
            write_address_d = bus.request_address_0;
            write_data_d    = bus.request_data_0;
          end
        end else if (transfer_1) begin
          grant_index_d = 1'b1;
          last_grant_d  = 1'b1;
          if (bus.request_address_1 != '0) begin
            write_enabled_d = 1'b1;
            write_address_d = bus.request_address_1;
            write_data_d    = bus.request_data_1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= CLEAR_ON_RESET ? CLEAR : RUN;
      clear_counter_q <= '0;
      last_grant_q    <= 1'b1;
      write_enabled_q <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      grant_index_q   <= 1'b0;
      init_done_q     <= !CLEAR_ON_RESET;
    end else begin
      state_q         <= state_d;
      clear_counter_q <= clear_counter_d;
      last_grant_q    <= last_grant_d;
      write_enabled_q <= write_enabled_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      grant_index_q   <= grant_index_d;
      init_done_q     <= init_done_d;
    end
  end

  assign bus.request_ready_0 = ready_0;
  assign bus.request_ready_1 = ready_1;
  assign bus.write_enabled   = write_enabled_q;
  assign bus.write_address   = write_address_q;
  assign bus.write_data      = write_data_q;
  assign bus.grant_index     = grant_index_q;
  assign bus.init_done       = init_done_q;

endmodule

// File: doc/register_file_write_arbiter.md
# register_file_write_arbiter

Sequencer and arbiter for the register file write port. After reset it clears every register to zero by walking the write port through all addresses. It then shares the single write port between two writeback requesters using valid/ready handshakes and round-robin priority. It sits between the writeback sources and the register file's `write_enabled` / `write_address` / `write_data` inputs; the read ports are untouched.

## Interface
- `ADDRESS_WIDTH`, 5, register address width; register count is 2^ADDRESS_WIDTH
- `DATA_WIDTH`, 32, register data width
- `CLEAR_ON_RESET`, 1, 1 = run the clear sequence after reset; 0 = go straight to RUN
- `clock`  input  1  single clock, all state updates on rising edge
- `reset_n`  input  1  synchronous, active-low reset
- `request_valid_0`  input  1  requester 0 has a write pending
- `request_ready_0`  output  1  requester 0 write accepted this cycle when valid
- `request_address_0`  input  ADDRESS_WIDTH  requester 0 target register
- `request_data_0`  input  DATA_WIDTH  requester 0 data
- `request_valid_1`, `request_ready_1`, `request_address_1`, `request_data_1`: same as requester 0, for requester 1
- `write_enabled`  output  1  to register file, registered
- `write_address`  output  ADDRESS_WIDTH  to register file, registered
- `write_data`  output  DATA_WIDTH  to register file, registered
- `grant_index`  output  1  requester whose write is on the port this cycle, registered
- `init_done`  output  1  high once the clear sequence has been issued, registered

## Operation
- States: CLEAR, RUN.
- Reset (reset_n low at an edge) sets:
  - state = CLEAR if CLEAR_ON_RESET=1, else RUN
  - clear_counter = 0, last_grant = 1
  - write_enabled = 0, write_address = 0, write_data = 0, grant_index = 0
  - init_done = CLEAR_ON_RESET ? 0 : 1
- CLEAR state:
  - Each edge: write_enabled<=1, write_address<=clear_counter, write_data<=0, clear_counter++.
  - On the edge that issues the last address (all ones): state<=RUN, init_done<=1.
  - Both `request_ready_*` are held 0 throughout.
- RUN state, arbitration (combinational on valids and last_grant):
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
- `request_ready_n` = (state==RUN) && granted(n). Ready is never high for both requesters in the same cycle.
- Handshake: a transfer occurs when valid && ready in the same cycle.
  - Requesters hold address/data stable while valid && !ready.
  - Deasserting valid without a transfer is allowed.
- On a transfer by requester n, at the next edge:
  - write_enabled<=1, write_address<=addr_n, write_data<=data_n
  - grant_index<=n, last_grant<=n
- No transfer: write_enabled<=0; address, data and grant_index hold their previous values.
- Address 0 in RUN: the request is accepted (ready asserted, last_grant updated) but write_enabled<=0. Register 0 stays zero.
- Same address from both requesters: they are serviced in round-robin order across two cycles, so the later grant wins.

## Timing
- Latency: handshake in cycle t → register file write on the edge ending cycle t+1. One write per cycle maximum; full throughput of 1 write/cycle with either or both requesters.
- Clear sequence: 2^ADDRESS_WIDTH cycles (32 by default).
  - First clear write is issued on the first edge with reset_n high.
  - init_done rises with the address-31 write.
  - The earliest request handshake is in the following cycle.
- Reset mid-CLEAR: the counter restarts at 0 and the full sweep repeats.
- Reset mid-RUN:
  - A handshake in the same cycle as reset_n low is discarded; no write is issued.
  - Ready goes 0 for the duration of CLEAR.
- Starvation bound: a held-valid requester is granted within 2 cycles in RUN.
- reset_n low for multiple cycles: outputs stay at their reset values; no writes are issued.

## Test plan
- **Reset clear:** reset_n low 3 cycles, then high, with both valids high.
  - Required: write_enabled high 32 consecutive cycles, addresses 0..31, data 0.
  - Required: ready_0 = ready_1 = 0 throughout; init_done rises with address 31.
- **Single requester:** after init, requester 0 sends addr 5'h10 data 32'h0000ffff, then 5'h11 data 32'h1111ffff on back-to-back cycles.
  - Required: ready_0 high both cycles.
  - Required: writes appear one cycle later, in order, with grant_index=0.
- **Contention:** both valid continuously (req0 addr 5'h12 data 32'h2222ffff, req1 addr 5'h13 data 32'h3333ffff).
  - Required: the first grant goes to requester 0 (last_grant=1 after reset), then grants alternate 0,1,0,1.
  - Required: ready is never high for both requesters in one cycle.
- **Address-zero drop:** requester 1 sends addr 0 data 32'hffffffff.
  - Required: ready_1 high; next cycle write_enabled=0.
  - Required: last_grant=1, so next contention grants requester 0.
- **Mid-operation reset:** reset_n low for 1 cycle during a 4-beat burst from requester 0.
  - Required: the beat in the reset cycle produces no write.
  - Required: the clear sweep restarts at address 0; the remaining beats stall until init_done.
- **CLEAR_ON_RESET=0:** release reset with request_valid_0 high (addr 5'h14 data 32'h4444ffff).
  - Required: init_done=1 from reset; ready_0 high in the first cycle.
  - Required: the write appears on the next edge.
